// File: rtl/xadc_drp_sampler_if.sv
// DRP bus between the XADC sampler (master) and the XADC primitive (slave).
// Read-only use: the master issues den/daddr and waits for drdy/do_in.
interface xadc_drp_sampler_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] do_in;
  logic        drdy;

  modport master (output daddr, den, dwe, di, input do_in, drdy);
  modport slave  (input daddr, den, dwe, di, output do_in, drdy);
endinterface

// File: rtl/xadc_drp_sampler.sv
// Reads each completed XADC conversion over DRP and emits a scaled, extended sample.
// Define XADC_SAMPLER_OVERRUN_EN to add the overrun_cnt drop counter output.
module xadc_drp_sampler #(
  parameter int TIMEOUT    = 255,
  parameter int BIPOLAR    = 0,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                      clock_in,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      eoc,
  input  logic [4:0]                channel,
  xadc_drp_sampler_if.master        drp,
  output logic [27:0]               signal_out,
  output logic                      sample_valid,
  output logic                      timeout_err
`ifdef XADC_SAMPLER_OVERRUN_EN
  ,
  output logic [7:0]                overrun_cnt
`endif
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [4:0]    chan_reg, chan_next;
  logic          pend_reg, pend_next;
  logic [4:0]    pend_chan_reg, pend_chan_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [27:0]   signal_out_reg, signal_out_next;
  logic          timeout_err_reg, timeout_err_next;
  logic          accept;
  logic          drop;

  logic [11:0]   code;
  logic [27:0]   code_ext;
  logic [27:0]   code_scaled;
  logic          unused_do_bits;

  assign accept         = enable & eoc;
  assign code           = drp.do_in[15:4];
  assign unused_do_bits = ^drp.do_in[3:0];

  if (BIPOLAR != 0) begin : g_bipolar
    assign code_ext = {{16{code[11]}}, code};
  end else begin : g_unipolar
    assign code_ext = {16'h0000, code};
  end

  // Gain is a plain left shift; bits pushed past bit 27 are discarded.
  assign code_scaled = code_ext << GAIN_SHIFT;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      chan_reg        <= '0;
      pend_reg        <= 1'b0;
      pend_chan_reg   <= '0;
      timer_reg       <= '0;
      signal_out_reg  <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      chan_reg        <= chan_next;
      pend_reg        <= pend_next;
      pend_chan_reg   <= pend_chan_next;
      timer_reg       <= timer_next;
      signal_out_reg  <= signal_out_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    chan_next        = chan_reg;
    pend_next        = pend_reg;
    pend_chan_next   = pend_chan_reg;
    timer_next       = timer_reg;
    signal_out_next  = signal_out_reg;
    timeout_err_next = timeout_err_reg;
    drop             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pend_reg) begin
          // Serve the queued entry; a coincident eoc takes its place.
          state_next = REQ;
          chan_next  = pend_chan_reg;
          pend_next  = accept;
          if (accept) begin
            pend_chan_next = channel;
          end
        end else if (accept) begin
          state_next = REQ;
          chan_next  = channel;
        end
      end
      REQ: begin
        timer_next = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (drp.drdy) begin
          signal_out_next = code_scaled;
          state_next      = OUT;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // One-deep queue for conversions finishing while a read is in flight.
    if (state_reg != IDLE && accept) begin
      if (!pend_reg) begin
        pend_next      = 1'b1;
        pend_chan_next = channel;
      end else begin
        drop = 1'b1;
      end
    end
  end

  assign drp.den      = (state_reg == REQ);
  assign drp.daddr    = {2'b00, chan_reg};
  assign drp.dwe      = 1'b0;
  assign drp.di       = 16'h0000;
  assign sample_valid = (state_reg == OUT);
  assign signal_out   = signal_out_reg;
  assign timeout_err  = timeout_err_reg;

`ifdef XADC_SAMPLER_OVERRUN_EN
  logic [7:0] overrun_cnt_reg;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt_reg <= 8'd0;
    end else if (drop && overrun_cnt_reg != 8'hFF) begin
      overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
    end
  end

  assign overrun_cnt = overrun_cnt_reg;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Directed bench: two sampler instances (unipolar/unity gain and bipolar/gain 16)
// share the same stimulus; each step compares outputs against hand-computed values.
module tb_xadc_drp_sampler;

  logic        clock_in = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        eoc;
  logic [4:0]  channel;
  logic        drdy;
  logic [15:0] do_val;

  logic [27:0] so0, so1;
  logic        sv0, sv1, te0, te1;
`ifdef XADC_SAMPLER_OVERRUN_EN
  logic [7:0]  oc0, oc1;
`endif

  int checks   = 0;
  int failures = 0;
  int sv_count = 0;
  int den_count = 0;
  int sv_snap;
  int den_snap;

  always #5 clock_in = ~clock_in;

  xadc_drp_sampler_if bus0 ();
  xadc_drp_sampler_if bus1 ();

  assign bus0.do_in = do_val;
  assign bus0.drdy  = drdy;
  assign bus1.do_in = do_val;
  assign bus1.drdy  = drdy;

  xadc_drp_sampler #(.TIMEOUT(255), .BIPOLAR(0), .GAIN_SHIFT(0)) dut0 (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .eoc          (eoc),
    .channel      (channel),
    .drp          (bus0.master),
    .signal_out   (so0),
    .sample_valid (sv0),
    .timeout_err  (te0)
`ifdef XADC_SAMPLER_OVERRUN_EN
    ,
    .overrun_cnt  (oc0)
`endif
  );

  xadc_drp_sampler #(.TIMEOUT(255), .BIPOLAR(1), .GAIN_SHIFT(4)) dut1 (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .enable       (enable),
    .eoc          (eoc),
    .channel      (channel),
    .drp          (bus1.master),
    .signal_out   (so1),
    .sample_valid (sv1),
    .timeout_err  (te1)
`ifdef XADC_SAMPLER_OVERRUN_EN
    ,
    .overrun_cnt  (oc1)
`endif
  );

  always @(posedge clock_in) begin
    if (sv0 === 1'b1) sv_count <= sv_count + 1;
    if (bus0.den === 1'b1) den_count <= den_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock_in);
    #1;
  endtask

  // One full read: eoc at cycle 0, den at cycle 1, drdy at cycle 5, sample at cycle 6.
  task automatic read_txn(input string tag, input logic [4:0] ch, input logic [15:0] data,
                          input logic [27:0] exp0, input logic [27:0] exp1);
    enable = 1'b1; eoc = 1'b1; channel = ch;
    tick;
    eoc = 1'b0;
    chk({tag, "_den"}, bus0.den, 1'b1);
    chk({tag, "_daddr"}, bus0.daddr, {2'b00, ch});
    chk({tag, "_dwe_di"}, {bus0.dwe, bus0.di}, 17'h0);
    tick;
    chk({tag, "_den_one_cycle"}, bus0.den, 1'b0);
    tick; tick; tick;
    drdy = 1'b1; do_val = data;
    chk({tag, "_no_early_valid"}, sv0, 1'b0);
    tick;
    drdy = 1'b0;
    chk({tag, "_valid"}, {sv0, sv1}, 2'b11);
    chk({tag, "_out_uni"}, so0, exp0);
    chk({tag, "_out_bip"}, so1, exp1);
    $display("read %s ch=%0h do=%0h uni=%0h bip=%0h", tag, ch, data, so0, so1);
    tick;
    chk({tag, "_valid_drop"}, sv0, 1'b0);
    chk({tag, "_hold"}, so0, exp0);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; eoc = 1'b0; channel = 5'd0; drdy = 1'b0; do_val = 16'h0;
    #3;
    chk("rst_den", bus0.den, 1'b0);
    chk("rst_daddr", bus0.daddr, 7'h00);
    chk("rst_valid", sv0, 1'b0);
    chk("rst_out", so0, 28'h0);
    chk("rst_err", te0, 1'b0);
    @(posedge clock_in); @(posedge clock_in); #1;
    reset_n = 1'b1;
    tick;

    read_txn("basic",   5'h03, 16'hABC0, 28'h0000ABC, 28'hFFFABC0);
    read_txn("signmin", 5'h1F, 16'h8000, 28'h0000800, 28'hFFF8000);
    read_txn("allones", 5'h00, 16'hFFF0, 28'h0000FFF, 28'hFFFFFF0);
    read_txn("posmax",  5'h10, 16'h7FF0, 28'h00007FF, 28'h0007FF0);

    // drdy while idle must not produce a sample
    drdy = 1'b1; do_val = 16'h1230;
    tick;
    drdy = 1'b0;
    chk("idle_drdy_valid", sv0, 1'b0);
    tick;
    chk("idle_drdy_valid2", sv0, 1'b0);
    chk("idle_drdy_hold", so0, 28'h00007FF);

    // eoc with enable low is not accepted
    enable = 1'b0; eoc = 1'b1; channel = 5'h07;
    tick;
    chk("disabled_den", bus0.den, 1'b0);
    eoc = 1'b0;
    tick;
    chk("disabled_den2", bus0.den, 1'b0);
    enable = 1'b1;

    // overrun: ch1 read, ch2 queued, ch3 dropped
    den_snap = den_count;
    eoc = 1'b1; channel = 5'h01;
    tick;
    chk("ovr_den1", bus0.daddr, 7'h01);
    channel = 5'h02;
    tick;
    channel = 5'h03;
    tick;
    eoc = 1'b0;
    tick;
    drdy = 1'b1; do_val = 16'h1110;
    tick;
    drdy = 1'b0;
    chk("ovr_sample1", {sv0, so0}, {1'b1, 28'h0000111});
    tick;
    chk("ovr_idle_gap", bus0.den, 1'b0);
    tick;
    chk("ovr_den2", {bus0.den, bus0.daddr}, {1'b1, 7'h02});
    tick; tick;
    drdy = 1'b1; do_val = 16'h2220;
    tick;
    drdy = 1'b0;
    chk("ovr_sample2", {sv0, so0}, {1'b1, 28'h0000222});
    $display("read overrun ch=2 uni=%0h", so0);
    repeat (6) tick;
    chk("ovr_two_reads", den_count - den_snap, 2);
`ifdef XADC_SAMPLER_OVERRUN_EN
    chk("ovr_cnt", oc0, 8'd1);
`endif

    // eoc coincident with pending-driven IDLE->REQ becomes the new pending entry
    eoc = 1'b1; channel = 5'h04;
    tick;
    eoc = 1'b0;
    tick;
    eoc = 1'b1; channel = 5'h06;
    tick;
    eoc = 1'b0; drdy = 1'b1; do_val = 16'h0010;
    tick;
    drdy = 1'b0;
    chk("pend_sample_a", {sv0, so0}, {1'b1, 28'h0000001});
    tick;
    eoc = 1'b1; channel = 5'h09;
    tick;
    eoc = 1'b0;
    chk("pend_den_b", {bus0.den, bus0.daddr}, {1'b1, 7'h06});
    tick;
    drdy = 1'b1; do_val = 16'h0020;
    tick;
    drdy = 1'b0;
    chk("pend_sample_b", {sv0, so0}, {1'b1, 28'h0000002});
    tick; tick;
    chk("pend_den_c", {bus0.den, bus0.daddr}, {1'b1, 7'h09});
    tick;
    drdy = 1'b1; do_val = 16'h0030;
    tick;
    drdy = 1'b0;
    chk("pend_sample_c", {sv0, so0}, {1'b1, 28'h0000003});
    $display("read pending chain ch=4,6,9 last uni=%0h", so0);
    tick;
`ifdef XADC_SAMPLER_OVERRUN_EN
    chk("pend_cnt_same", oc0, 8'd1);
`endif

    // timeout: drdy never arrives
    eoc = 1'b1; channel = 5'h08;
    tick;
    eoc = 1'b0;
    chk("to_den", bus0.den, 1'b1);
    sv_snap = sv_count;
    repeat (255) tick;
    chk("to_not_yet", te0, 1'b0);
    tick;
    chk("to_err", {te0, te1}, 2'b11);
    chk("to_no_sample", sv_count - sv_snap, 0);
    $display("read timeout ch=8 timeout_err=%0b", te0);
    read_txn("after_to", 5'h0A, 16'h5550, 28'h0000555, 28'h0005550);
    chk("to_sticky", te0, 1'b1);

    // reset mid-WAIT, then a stray drdy
    eoc = 1'b1; channel = 5'h11;
    tick;
    eoc = 1'b0;
    tick; tick;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clear", {te0, sv0, bus0.den}, 3'b000);
    chk("mid_rst_out", so0, 28'h0);
    chk("mid_rst_daddr", bus0.daddr, 7'h00);
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    drdy = 1'b1; do_val = 16'hFFF0;
    tick;
    drdy = 1'b0;
    chk("mid_rst_no_valid", sv0, 1'b0);
    tick;
    chk("mid_rst_no_valid2", {sv0, bus0.den}, 2'b00);
    chk("mid_rst_out_hold", so0, 28'h0);
`ifdef XADC_SAMPLER_OVERRUN_EN
    chk("mid_rst_cnt", oc0, 8'd0);
`endif
    $display("read reset_mid_wait ch=11 abandoned");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
